param_ping_pong_counter: RTL and testbench

//   Parametrised ping-pong counter: bounces between run-time min_i/max_i with programmable step.

---
 rtl/param_ping_pong_counter_pkg.sv | 15 +
 rtl/param_ping_pong_counter_next_value.sv | 73 +++++++
 rtl/param_ping_pong_counter.sv | 110 +++++++++++
 tb/tb_param_ping_pong_counter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_ping_pong_counter_pkg.sv
// Shared types and constants for the ping-pong counter.
package pp_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/param_ping_pong_counter_next_value.sv
// Combinational next-count calculation for one advance of the ping-pong counter.
module pp_next_value
    import pp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir,
    output logic             hit
);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] hi_x;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] lo_plus;

    // One extra bit keeps count+step and lo+step from overflowing.
    assign cnt_x   = {1'b0, count};
    assign hi_x    = {1'b0, hi};
    assign sum     = cnt_x + {1'b0, step};
    assign diff    = cnt_x - {1'b0, step};
    assign lo_plus = {1'b0, lo} + {1'b0, step};

    always_comb begin
        next_count = count;
        next_dir   = dir;
        hit        = 1'b0;
        if (mode == MODE_BOUNCE) begin
            if (dir == DIR_UP) begin
                if (sum >= hi_x) begin
                    next_count = hi;
                    next_dir   = DIR_DOWN;
                    hit        = 1'b1;
                end else begin
                    next_count = sum[WIDTH-1:0];
                end
            end else begin
                // Landing exactly on lo also counts as a bounce.
                if (cnt_x <= lo_plus) begin
                    next_count = lo;
                    next_dir   = DIR_UP;
                    hit        = 1'b1;
                end else begin
                    next_count = diff[WIDTH-1:0];
                end
            end
        end else begin
            if (dir == DIR_UP) begin
                if (sum > hi_x) begin
                    next_count = lo;
                    hit        = 1'b1;
                end else begin
                    next_count = sum[WIDTH-1:0];
                end
            end else begin
                if (cnt_x < lo_plus) begin
                    next_count = hi;
                    hit        = 1'b1;
                end else begin
                    next_count = diff[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/param_ping_pong_counter.sv
// Tick-driven ping-pong counter with bounce/wrap modes, held flip requests and an event counter.
//   state | meaning
//   LOAD  | next edge loads count=min, dir=up, clears pending flip
//   RUN   | counting on enabled ticks, valid_o=1
//   HALT  | bounds invalid or count out of range; count/dir frozen
module param_ping_pong_counter
    import pp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int BCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              enable_i,
    input  logic              flip_i,
    input  logic              mode_i,
    input  logic [WIDTH-1:0]  min_i,
    input  logic [WIDTH-1:0]  max_i,
    input  logic [WIDTH-1:0]  step_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              dir_o,
    output logic              valid_o,
    output logic              evt_o,
    output logic [BCNT_W-1:0] bcnt_o
);

    state_t           state;
    state_t           state_nxt;
    logic             flip_pend;
    logic             range_ok;
    logic             in_range;
    logic             run_ok;
    logic [WIDTH-1:0] step_eff;
    logic             dir_eff;
    logic [WIDTH-1:0] nv_count;
    logic             nv_dir;
    logic             nv_hit;

    assign range_ok = max_i > min_i;
    assign in_range = (count_o >= min_i) && (count_o <= max_i);
    assign run_ok   = range_ok && in_range;
    assign step_eff = (step_i == '0) ? WIDTH'(1) : step_i;
    assign dir_eff  = dir_o ^ (flip_pend | flip_i);

    pp_next_value #(.WIDTH(WIDTH)) u_next (
        .count      (count_o),
        .dir        (dir_eff),
        .step       (step_eff),
        .lo         (min_i),
        .hi         (max_i),
        .mode       (mode_i),
        .next_count (nv_count),
        .next_dir   (nv_dir),
        .hit        (nv_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = range_ok ? RUN : HALT;
            RUN:     state_nxt = run_ok ? RUN : HALT;
            HALT:    if (range_ok) state_nxt = in_range ? RUN : LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        valid_o = (state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_o   <= '0;
            dir_o     <= DIR_UP;
            evt_o     <= 1'b0;
            bcnt_o    <= '0;
            flip_pend <= 1'b0;
        end else begin
            evt_o <= 1'b0;
            case (state)
                LOAD: begin
                    count_o   <= min_i;
                    dir_o     <= DIR_UP;
                    flip_pend <= 1'b0;
                end
                RUN: begin
                    if (enable_i) begin
                        if (tick_i && run_ok) begin
                            count_o   <= nv_count;
                            dir_o     <= nv_dir;
                            evt_o     <= nv_hit;
                            bcnt_o    <= bcnt_o + BCNT_W'(nv_hit);
                            flip_pend <= 1'b0;
                        end else if (flip_i) begin
                            flip_pend <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_ping_pong_counter.sv
// Directed self-checking bench for param_ping_pong_counter.
module tb_param_ping_pong_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_i = 1'b0;
    logic       enable_i = 1'b1;
    logic       flip_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [3:0] min_i = 4'd0;
    logic [3:0] max_i = 4'd0;
    logic [3:0] step_i = 4'd1;
    logic [3:0] count_o;
    logic       dir_o;
    logic       valid_o;
    logic       evt_o;
    logic [7:0] bcnt_o;

    int total = 0;
    int bad = 0;

    param_ping_pong_counter #(.WIDTH(4), .BCNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_i   (tick_i),
        .enable_i (enable_i),
        .flip_i   (flip_i),
        .mode_i   (mode_i),
        .min_i    (min_i),
        .max_i    (max_i),
        .step_i   (step_i),
        .count_o  (count_o),
        .dir_o    (dir_o),
        .valid_o  (valid_o),
        .evt_o    (evt_o),
        .bcnt_o   (bcnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after an edge and are sampled there too.
    task automatic cyc(input logic t, input logic f);
        tick_i = t;
        flip_i = f;
        @(posedge clk);
        #1;
        tick_i = 1'b0;
        flip_i = 1'b0;
    endtask

    // Reset, release, then the LOAD edge.
    task automatic start(input logic [3:0] lo, input logic [3:0] hi,
                         input logic [3:0] st, input logic md);
        rst = 1'b1;
        min_i = lo; max_i = hi; step_i = st; mode_i = md;
        enable_i = 1'b1; tick_i = 1'b0; flip_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        min_i = 4'd4; max_i = 4'd8; step_i = 4'd1; mode_i = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (count_o !== 4'd0 || dir_o !== 1'b0 || valid_o !== 1'b0 || evt_o !== 1'b0 || bcnt_o !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: got count=%0d dir=%b valid=%b evt=%b bcnt=%0d want 0/0/0/0/0",
                     count_o, dir_o, valid_o, evt_o, bcnt_o);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        total++;
        if (count_o !== 4'd4 || dir_o !== 1'b0 || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_load: got count=%0d dir=%b valid=%b want 4/0/1", count_o, dir_o, valid_o);
        end
    endtask

    task automatic run_seq(input string name, input logic [3:0] ec[7], input logic ed[7], input logic ee[7]);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0);
            total++;
            if (count_o !== ec[i] || dir_o !== ed[i] || evt_o !== ee[i]) begin
                bad++;
                $display("FAIL %s step %0d: got count=%0d dir=%b evt=%b want %0d/%b/%b",
                         name, i, count_o, dir_o, evt_o, ec[i], ed[i], ee[i]);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] ec1[7] = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3};
        logic [3:0] ec2[7] = '{4'd3, 4'd5, 4'd6, 4'd4, 4'd2, 4'd1, 4'd3};
        logic       ed[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ee[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        start(4'd2, 4'd5, 4'd1, 1'b0);
        total++;
        if (count_o !== 4'd2) begin
            bad++;
            $display("FAIL t1_load: got count=%0d want 2", count_o);
        end
        run_seq("t1_bounce", ec1, ed, ee);
        total++;
        if (bcnt_o !== 8'd2) begin
            bad++;
            $display("FAIL t1_bcnt: got %0d want 2", bcnt_o);
        end
        start(4'd1, 4'd6, 4'd2, 1'b0);
        run_seq("t2_bounce", ec2, ed, ee);
        total++;
        if (bcnt_o !== 8'd2) begin
            bad++;
            $display("FAIL t2_bcnt: got %0d want 2", bcnt_o);
        end
    endtask

    task automatic test_step_zero;
        start(4'd0, 4'd3, 4'd0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd2 || dir_o !== 1'b0) begin
            bad++;
            $display("FAIL step_zero: got count=%0d dir=%b want 2/0", count_o, dir_o);
        end
    endtask

    task automatic test_flip;
        start(4'd0, 4'd9, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, (i == 2 || i == 5));
        total++;
        if (count_o !== 4'd3 || dir_o !== 1'b0) begin
            bad++;
            $display("FAIL flip_gap_hold: got count=%0d dir=%b want 3/0", count_o, dir_o);
        end
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd2 || dir_o !== 1'b1) begin
            bad++;
            $display("FAIL flip_double: got count=%0d dir=%b want 2/1", count_o, dir_o);
        end
        cyc(1'b1, 1'b1);
        total++;
        if (count_o !== 4'd3 || dir_o !== 1'b0) begin
            bad++;
            $display("FAIL flip_coincident: got count=%0d dir=%b want 3/0", count_o, dir_o);
        end
        cyc(1'b0, 1'b1);
        enable_i = 1'b0;
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd3 || dir_o !== 1'b0) begin
            bad++;
            $display("FAIL tick_disabled: got count=%0d dir=%b want 3/0", count_o, dir_o);
        end
        enable_i = 1'b1;
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd2 || dir_o !== 1'b1) begin
            bad++;
            $display("FAIL flip_kept: got count=%0d dir=%b want 2/1", count_o, dir_o);
        end
        enable_i = 1'b0;
        cyc(1'b0, 1'b1);
        enable_i = 1'b1;
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd1 || dir_o !== 1'b1) begin
            bad++;
            $display("FAIL flip_ignored_disabled: got count=%0d dir=%b want 1/1", count_o, dir_o);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] st[10] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd5};
        logic       fl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] ec[10] = '{4'd4, 4'd6, 4'd2, 4'd3, 4'd7, 4'd5, 4'd3, 4'd7, 4'd2, 4'd7};
        logic       ed[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ee[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        start(4'd2, 4'd7, 4'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step_i = st[i];
            cyc(1'b1, fl[i]);
            total++;
            if (count_o !== ec[i] || dir_o !== ed[i] || evt_o !== ee[i]) begin
                bad++;
                $display("FAIL wrap step %0d: got count=%0d dir=%b evt=%b want %0d/%b/%b",
                         i, count_o, dir_o, evt_o, ec[i], ed[i], ee[i]);
            end
        end
        total++;
        if (bcnt_o !== 8'd4) begin
            bad++;
            $display("FAIL wrap_bcnt: got %0d want 4", bcnt_o);
        end
    endtask

    task automatic test_halt;
        start(4'd3, 4'd8, 4'd1, 1'b0);
        max_i = 4'd3;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        total++;
        if (valid_o !== 1'b0 || count_o !== 4'd3) begin
            bad++;
            $display("FAIL halt_enter: got valid=%b count=%0d want 0/3", valid_o, count_o);
        end
        max_i = 4'd9;
        cyc(1'b0, 1'b0);
        total++;
        if (valid_o !== 1'b1 || count_o !== 4'd3) begin
            bad++;
            $display("FAIL halt_resume: got valid=%b count=%0d want 1/3", valid_o, count_o);
        end
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd4 || dir_o !== 1'b0) begin
            bad++;
            $display("FAIL halt_count: got count=%0d dir=%b want 4/0", count_o, dir_o);
        end
        min_i = 4'd6; max_i = 4'd6;
        cyc(1'b1, 1'b0);
        min_i = 4'd6; max_i = 4'd9;
        cyc(1'b0, 1'b0);
        total++;
        if (valid_o !== 1'b0 || count_o !== 4'd4) begin
            bad++;
            $display("FAIL halt_to_load: got valid=%b count=%0d want 0/4", valid_o, count_o);
        end
        cyc(1'b0, 1'b0);
        total++;
        if (valid_o !== 1'b1 || count_o !== 4'd6) begin
            bad++;
            $display("FAIL reload: got valid=%b count=%0d want 1/6", valid_o, count_o);
        end
    endtask

    task automatic test_async_reset;
        start(4'd5, 4'd9, 4'd2, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd9 || dir_o !== 1'b1 || evt_o !== 1'b1 || bcnt_o !== 8'd1) begin
            bad++;
            $display("FAIL pre_reset: got count=%0d dir=%b evt=%b bcnt=%0d want 9/1/1/1",
                     count_o, dir_o, evt_o, bcnt_o);
        end
        cyc(1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (count_o !== 4'd0 || dir_o !== 1'b0 || valid_o !== 1'b0 || evt_o !== 1'b0 || bcnt_o !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: got count=%0d dir=%b valid=%b evt=%b bcnt=%0d want all 0",
                     count_o, dir_o, valid_o, evt_o, bcnt_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        total++;
        if (count_o !== 4'd5 || dir_o !== 1'b0 || bcnt_o !== 8'd0) begin
            bad++;
            $display("FAIL post_reset_load: got count=%0d dir=%b bcnt=%0d want 5/0/0", count_o, dir_o, bcnt_o);
        end
        cyc(1'b1, 1'b0);
        total++;
        if (count_o !== 4'd7 || dir_o !== 1'b0 || evt_o !== 1'b0) begin
            bad++;
            $display("FAIL flip_discarded: got count=%0d dir=%b evt=%b want 7/0/0", count_o, dir_o, evt_o);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_step_zero();
        test_flip();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
